// File: rtl/exec_pkg.sv
// exec_pkg: shared opcodes, addressing modes and FSM states
// for the exec_unit execute stage and its multiply/divide helper.
package exec_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_INC = 4'h5;
  localparam logic [3:0] OP_DEC = 4'h6;
  localparam logic [3:0] OP_MUL = 4'h7;
  localparam logic [3:0] OP_DIV = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_MOV = 4'hB;

  localparam logic AM_REG = 1'b0;
  localparam logic AM_MEM = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // INC, DEC and SHL operate on rd in place
  function automatic logic uses_rd(input logic [3:0] op);
    return (op == OP_INC) || (op == OP_DEC) || (op == OP_SHL);
  endfunction

endpackage

// File: rtl/exec_muldiv.sv
// exec_muldiv: iterative shift-add multiplier / restoring divider,
// one bit per cycle; result is {hi, lo} = product or {rem, quo}.
module exec_muldiv
  import exec_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_div,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result,
  output logic                  div0
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic              run;
  logic              div_q;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] dsr;
  logic [DATA_W-1:0] hi_n;
  logic [DATA_W-1:0] lo_n;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   sh;

  // one iteration: add-and-shift-right, or shift-left-and-trial-subtract
  always_comb begin
    hi_n = hi;
    lo_n = lo;
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, dsr} : '0);
    sh   = {hi, lo[DATA_W-1]};
    if (div_q) begin
      if (sh >= {1'b0, dsr}) begin
        hi_n = sh[DATA_W-1:0] - dsr;
        lo_n = {lo[DATA_W-2:0], 1'b1};
      end else begin
        hi_n = sh[DATA_W-1:0];
        lo_n = {lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      hi_n = sum[DATA_W:1];
      lo_n = {sum[0], lo[DATA_W-1:1]};
    end
  end

  // the final iteration's value is handed out directly on the done cycle
  assign done   = run && (cnt == LAST);
  assign result = {hi_n, lo_n};
  assign div0   = div_q && (dsr == '0);

  // operand load on start, then DATA_W iterations
  always_ff @(posedge clk) begin
    if (reset) begin
      run   <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      dsr   <= '0;
    end else if (start) begin
      run   <= 1'b1;
      div_q <= is_div;
      cnt   <= '0;
      hi    <= '0;
      lo    <= a;
      dsr   <= b;
    end else if (run) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + CW'(1);
      if (cnt == LAST) run <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: handshaked execute stage; single-cycle ALU plus optional
// iterative MUL/DIV enabled by defining EXEC_MULDIV_EN.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int MEM_AW = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            opcode,
  input  logic                  am,
  input  logic [REG_AW-1:0]     rd,
  input  logic [REG_AW-1:0]     rs1,
  output logic [REG_AW-1:0]     rf_addr_a,
  input  logic [DATA_W-1:0]     rf_data_a,
  input  logic [DATA_W-1:0]     rf_data_b,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_W-1:0]   result,
  output logic [REG_AW-1:0]     wb_rd,
  output logic                  zero_flag,
  output logic                  carry_flag,
  output logic                  div0_flag,
  output logic                  illegal_flag
);

  if (DATA_W < 4 || MEM_AW < 1) begin : g_param_chk
    $error("exec_unit: DATA_W must be >= 4 and MEM_AW >= 1");
  end

  state_t              state_q;
  state_t              state_d;
  logic                accept;
  logic                is_md;
  logic [DATA_W-1:0]   opnd_b;
  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W:0]     ext;
  logic                alu_c;
  logic                alu_ill;
  logic                md_done;
  logic                md_div0;
  logic [2*DATA_W-1:0] md_res;

  assign rf_addr_a = uses_rd(opcode) ? rd : rs1;
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid && in_ready;

  // operand B source by addressing mode
  always_comb begin
    opnd_b = rf_data_b;
    unique case (am)
      AM_REG: opnd_b = rf_data_b;
      AM_MEM: opnd_b = mem_data;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  assign is_md = (opcode == OP_MUL) || (opcode == OP_DIV);

  exec_muldiv #(.DATA_W(DATA_W)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && is_md),
    .is_div (opcode == OP_DIV),
    .a      (rf_data_a),
    .b      (opnd_b),
    .done   (md_done),
    .result (md_res),
    .div0   (md_div0)
  );
`else
  assign is_md   = 1'b0;
  assign md_done = 1'b0;
  assign md_div0 = 1'b0;
  assign md_res  = '0;
`endif

  // single-cycle ALU; anything unrecognised is illegal
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_ill = 1'b0;
    ext     = '0;
    case (opcode)
      OP_ADD: begin
        ext     = {1'b0, rf_data_a} + {1'b0, opnd_b};
        alu_res = ext[DATA_W-1:0];
        alu_c   = ext[DATA_W];
      end
      OP_SUB: begin
        ext     = {1'b0, rf_data_a} - {1'b0, opnd_b};
        alu_res = ext[DATA_W-1:0];
        alu_c   = ext[DATA_W];
      end
      OP_INC: begin
        ext     = {1'b0, rf_data_a} + (DATA_W+1)'(1);
        alu_res = ext[DATA_W-1:0];
        alu_c   = ext[DATA_W];
      end
      OP_DEC: begin
        ext     = {1'b0, rf_data_a} - (DATA_W+1)'(1);
        alu_res = ext[DATA_W-1:0];
        alu_c   = ext[DATA_W];
      end
      OP_AND: alu_res = rf_data_a & opnd_b;
      OP_OR:  alu_res = rf_data_a | opnd_b;
      OP_XOR: alu_res = rf_data_a ^ opnd_b;
      OP_SHL: begin
        alu_res = {rf_data_a[DATA_W-2:0], 1'b0};
        alu_c   = rf_data_a[DATA_W-1];
      end
      OP_SHR: alu_res = {1'b0, rf_data_a[DATA_W-1:1]};
      OP_MOV: alu_res = opnd_b;
      default: alu_ill = 1'b1;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = is_md ? S_BUSY : S_DONE;
      S_BUSY: if (md_done) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // result, tag and flags change only when an operation completes
  always_ff @(posedge clk) begin
    if (reset) begin
      result       <= '0;
      wb_rd        <= '0;
      zero_flag    <= 1'b0;
      carry_flag   <= 1'b0;
      div0_flag    <= 1'b0;
      illegal_flag <= 1'b0;
    end else if (accept) begin
      wb_rd <= rd;
      if (!is_md) begin
        result       <= {{DATA_W{1'b0}}, alu_res};
        zero_flag    <= (alu_res == '0);
        carry_flag   <= alu_c;
        div0_flag    <= 1'b0;
        illegal_flag <= alu_ill;
      end
    end else if (md_done) begin
      result       <= md_res;
      zero_flag    <= (md_res == '0);
      carry_flag   <= 1'b0;
      div0_flag    <= md_div0;
      illegal_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed self-checking bench for exec_unit (DATA_W=8).
// MUL/DIV vectors apply when EXEC_MULDIV_EN is defined.
module tb_exec_unit;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = 4'h0;
  logic        am = 1'b0;
  logic [2:0]  rd = 3'd0;
  logic [2:0]  rs1 = 3'd0;
  logic [2:0]  rf_addr_a;
  logic [7:0]  rf_data_a = 8'h00;
  logic [7:0]  rf_data_b = 8'h00;
  logic [7:0]  mem_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic [2:0]  wb_rd;
  logic        zero_flag;
  logic        carry_flag;
  logic        div0_flag;
  logic        illegal_flag;

  int checks = 0;
  int errors = 0;
  logic bad;

  exec_unit #(.DATA_W(8), .REG_AW(3), .MEM_AW(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .am           (am),
    .rd           (rd),
    .rs1          (rs1),
    .rf_addr_a    (rf_addr_a),
    .rf_data_a    (rf_data_a),
    .rf_data_b    (rf_data_b),
    .mem_data     (mem_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .wb_rd        (wb_rd),
    .zero_flag    (zero_flag),
    .carry_flag   (carry_flag),
    .div0_flag    (div0_flag),
    .illegal_flag (illegal_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] flags();
    return 32'({zero_flag, carry_flag, div0_flag, illegal_flag});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic m,
                         input logic [2:0] d, input logic [2:0] s,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] mem);
    opcode    = op;
    am        = m;
    rd        = d;
    rs1       = s;
    rf_data_a = a;
    rf_data_b = b;
    mem_data  = mem;
    in_valid  = 1'b1;
    #1;
  endtask

  task automatic accept_step();
    step();
    in_valid = 1'b0;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic single(input string tag, input logic [3:0] op,
                        input logic m, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] mem,
                        input logic [15:0] exp_res,
                        input logic [3:0] exp_flags);
    present(op, m, 3'd1, 3'd2, a, b, mem);
    accept_step();
    chk({tag, "_valid"}, 32'(out_valid), 32'h1);
    chk({tag, "_res"}, 32'(result), 32'(exp_res));
    chk({tag, "_flags"}, flags(), 32'(exp_flags));
    retire();
  endtask

  initial begin
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_wb_rd", 32'(wb_rd), 32'h0);
    chk("rst_flags", flags(), 32'h0);
    reset = 1'b0;
    step();

    present(OP_ADD, 1'b0, 3'd2, 3'd6, 8'hF0, 8'h20, 8'h55);
    chk("add_addr_rs1", 32'(rf_addr_a), 32'h6);
    chk("add_in_ready", 32'(in_ready), 32'h1);
    accept_step();
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("add_res", 32'(result), 32'h0010);
    chk("add_flags", flags(), 32'h4);
    chk("add_wb_rd", 32'(wb_rd), 32'h2);

    present(OP_SUB, 1'b1, 3'd7, 3'd7, 8'h00, 8'h00, 8'h00);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      bad |= (result !== 16'h0010) || (flags() !== 32'h4) ||
             (wb_rd !== 3'd2) || (out_valid !== 1'b1) ||
             (in_ready !== 1'b0);
    end
    in_valid = 1'b0;
    chk("hold_stable", 32'(bad), 32'h0);
    retire();
    chk("retire_valid", 32'(out_valid), 32'h0);
    chk("retire_ready", 32'(in_ready), 32'h1);
    chk("flags_idle", flags(), 32'h4);

    single("sub_mem", OP_SUB, 1'b1, 8'h05, 8'h99, 8'h05, 16'h0, 4'b1000);

    present(OP_INC, 1'b0, 3'd3, 3'd5, 8'hFF, 8'h00, 8'h00);
    chk("inc_addr_rd", 32'(rf_addr_a), 32'h3);
    accept_step();
    chk("inc_res", 32'(result), 32'h0);
    chk("inc_flags", flags(), 32'hC);
    retire();

    single("dec", OP_DEC, 1'b0, 8'h00, 8'h11, 8'h22, 16'h00FF, 4'b0100);
    single("shl", OP_SHL, 1'b0, 8'h81, 8'h00, 8'h00, 16'h0002, 4'b0100);
    single("shr", OP_SHR, 1'b0, 8'h81, 8'h00, 8'h00, 16'h0040, 4'b0000);
    single("and", OP_AND, 1'b0, 8'hF0, 8'h3C, 8'h00, 16'h0030, 4'b0000);
    single("or",  OP_OR,  1'b0, 8'hA0, 8'h05, 8'h00, 16'h00A5, 4'b0000);
    single("xor", OP_XOR, 1'b0, 8'hAA, 8'hFF, 8'h00, 16'h0055, 4'b0000);
    single("mov", OP_MOV, 1'b1, 8'h11, 8'h22, 8'h3C, 16'h003C, 4'b0000);
    single("ill", 4'hE, 1'b0, 8'h12, 8'h34, 8'h56, 16'h0, 4'b1001);
    chk("ill_flag_held", flags(), 32'h9);

`ifdef EXEC_MULDIV_EN
    present(OP_MUL, 1'b0, 3'd4, 3'd1, 8'hFF, 8'hFF, 8'h00);
    accept_step();
    bad = out_valid | in_ready;
    for (int i = 0; i < 7; i++) begin
      step();
      bad |= out_valid | in_ready;
    end
    chk("mul_busy", 32'(bad), 32'h0);
    step();
    chk("mul_valid_9", 32'(out_valid), 32'h1);
    chk("mul_res", 32'(result), 32'hFE01);
    chk("mul_flags", flags(), 32'h0);
    chk("mul_wb_rd", 32'(wb_rd), 32'h4);
    retire();

    present(OP_DIV, 1'b0, 3'd1, 3'd1, 8'd200, 8'd7, 8'h00);
    accept_step();
    repeat (8) step();
    chk("div_valid", 32'(out_valid), 32'h1);
    chk("div_res", 32'(result), 32'h041C);
    chk("div_flags", flags(), 32'h0);
    retire();

    present(OP_DIV, 1'b1, 3'd1, 3'd1, 8'd9, 8'd5, 8'd0);
    accept_step();
    repeat (8) step();
    chk("div0_valid", 32'(out_valid), 32'h1);
    chk("div0_res", 32'(result), 32'h09FF);
    chk("div0_flags", flags(), 32'h2);
    retire();

    single("div0_clear", OP_ADD, 1'b0, 8'h01, 8'h01, 8'h00,
           16'h0002, 4'b0000);

    present(OP_MUL, 1'b0, 3'd5, 3'd1, 8'h0F, 8'h0F, 8'h00);
    accept_step();
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_valid", 32'(out_valid), 32'h0);
    chk("mrst_ready", 32'(in_ready), 32'h1);
    chk("mrst_flags", flags(), 32'h0);
    chk("mrst_result", 32'(result), 32'h0);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      bad |= out_valid;
    end
    chk("mrst_no_valid", 32'(bad), 32'h0);
`else
    single("mul_ill", OP_MUL, 1'b0, 8'h03, 8'h04, 8'h00, 16'h0, 4'b1001);
    single("div_ill", OP_DIV, 1'b0, 8'h09, 8'h03, 8'h00, 16'h0, 4'b1001);
`endif

    present(OP_ADD, 1'b0, 3'd6, 3'd1, 8'h01, 8'h02, 8'h00);
    accept_step();
    chk("drst_pre_valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("drst_valid", 32'(out_valid), 32'h0);
    chk("drst_ready", 32'(in_ready), 32'h1);
    chk("drst_result", 32'(result), 32'h0);
    chk("drst_wb_rd", 32'(wb_rd), 32'h0);
    chk("drst_flags", flags(), 32'h0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      bad |= out_valid;
    end
    chk("drst_no_valid", 32'(bad), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
